// File: rtl/keypad_pkg.sv
// Shared types, FSM encodings and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;

    typedef logic [3:0] key_code_t;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Active-low one-hot row drive for a row index.
    function automatic logic [KP_ROWS-1:0] row_drive(input logic [1:0] idx);
        return ~(KP_ROWS'(1) << idx);
    endfunction

    // Index of the lowest-numbered column pulled low.
    function automatic logic [1:0] first_low_col(input logic [KP_COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = int'(KP_COLS) - 1; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_stable_cnt.sv
// Saturating stability counter: counts consecutive matching cycles up to TERM-1.
module keypad_stable_cnt
#(
    parameter int unsigned TERM = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_match,
    output logic o_term_c
);

    localparam int unsigned CW = (TERM > 1) ? $clog2(TERM) : 1;

    logic [CW-1:0] r_cnt;

    assign o_term_c = (r_cnt == CW'(TERM - 1));

    // A mismatch restarts the stability window; terminal value holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || !i_match) begin
            r_cnt <= '0;
        end else if (!o_term_c) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_event_scanner.sv
// 4x4 keypad scanner emitting one debounced press strobe per physical press.
// Define KEYPAD_REPEAT_EN to add hold-to-repeat strobes.
module keypad_event_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_HOLD    = 4,
    parameter int unsigned DEBOUNCE     = 200,
    parameter int unsigned REPEAT_DELAY = 50000,
    parameter int unsigned REPEAT_RATE  = 10000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KP_COLS-1:0] col_in,
    output logic [KP_ROWS-1:0] row_scn,
    output key_code_t          key,
    output logic               pressed,
    output logic               held
);

    localparam int unsigned SW = $clog2(SCAN_HOLD);

    if (SCAN_HOLD < 2 || DEBOUNCE < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_check
        $error("keypad_event_scanner: invalid parameter set");
    end

    logic [1:0]         r_state,    w_state_nxt;
    logic [1:0]         r_row_idx,  w_row_idx_nxt;
    logic [1:0]         r_col_idx,  w_col_idx_nxt;
    logic [SW-1:0]      r_scan_cnt, w_scan_cnt_nxt;
    logic [KP_ROWS-1:0] r_row_scn;
    key_code_t          r_key,      w_key_nxt;
    logic               r_pressed,  w_pressed_nxt;
    logic               r_held,     w_held_nxt;

    logic w_cap_low;
    logic w_cnt_clear;
    logic w_cnt_match;
    logic w_term;
    logic w_rep_fire;

    assign w_cap_low   = !col_in[r_col_idx];
    assign w_cnt_clear = (r_state == ST_SCAN) || (r_state == ST_HELD);
    assign w_cnt_match = (r_state == ST_RELEASE) ? !w_cap_low : w_cap_low;

    keypad_stable_cnt #(
        .TERM (DEBOUNCE)
    ) u_stable_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_cnt_clear),
        .i_match  (w_cnt_match),
        .o_term_c (w_term)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_first;
    logic          w_rep_active;

    assign w_rep_active = (r_state == ST_HELD) || (r_state == ST_RELEASE);
    assign w_rep_fire   = w_rep_active &&
                          (r_rep_cnt == (r_rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));

    // Hold timer restarts at every press strobe and survives release bounce.
    always_ff @(posedge clk) begin
        if (rst || !w_rep_active) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= r_rep_cnt + RW'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_row_idx_nxt  = r_row_idx;
        w_col_idx_nxt  = r_col_idx;
        w_scan_cnt_nxt = r_scan_cnt;
        w_key_nxt      = r_key;
        w_pressed_nxt  = 1'b0;
        w_held_nxt     = r_held;
        case (r_state)
            ST_SCAN: begin
                if (r_scan_cnt == SW'(SCAN_HOLD - 1)) begin
                    w_scan_cnt_nxt = '0;
                    if (!(&col_in)) begin
                        w_col_idx_nxt = first_low_col(col_in);
                        w_state_nxt   = ST_DEBOUNCE;
                    end else begin
                        w_row_idx_nxt = r_row_idx + 2'd1;
                    end
                end else begin
                    w_scan_cnt_nxt = r_scan_cnt + SW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!w_cap_low) begin
                    w_state_nxt   = ST_SCAN;
                    w_row_idx_nxt = r_row_idx + 2'd1;
                end else if (w_term) begin
                    w_key_nxt     = {r_row_idx, r_col_idx};
                    w_pressed_nxt = 1'b1;
                    w_held_nxt    = 1'b1;
                    w_state_nxt   = ST_HELD;
                end
            end
            ST_HELD: begin
                w_pressed_nxt = w_rep_fire;
                if (!w_cap_low) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                w_pressed_nxt = w_rep_fire;
                if (w_cap_low) begin
                    w_state_nxt = ST_HELD;
                end else if (w_term) begin
                    w_pressed_nxt = 1'b0;
                    w_held_nxt    = 1'b0;
                    w_state_nxt   = ST_SCAN;
                    w_row_idx_nxt = r_row_idx + 2'd1;
                end
            end
            default: w_state_nxt = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SCAN;
            r_row_idx  <= 2'd0;
            r_col_idx  <= 2'd0;
            r_scan_cnt <= '0;
            r_row_scn  <= row_drive(2'd0);
            r_key      <= '0;
            r_pressed  <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row_idx  <= w_row_idx_nxt;
            r_col_idx  <= w_col_idx_nxt;
            r_scan_cnt <= w_scan_cnt_nxt;
            r_row_scn  <= row_drive(w_row_idx_nxt);
            r_key      <= w_key_nxt;
            r_pressed  <= w_pressed_nxt;
            r_held     <= w_held_nxt;
        end
    end

    assign row_scn = r_row_scn;
    assign key     = r_key;
    assign pressed = r_pressed;
    assign held    = r_held;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Self-checking bench for keypad_event_scanner with a behavioural keypad matrix.
module tb_keypad_event_scanner;

    localparam int SH        = 2;
    localparam int DB        = 4;
    localparam int REP_DELAY = 20;
    localparam int REP_RATE  = 8;
    localparam int LAT_MIN   = DB + 1;
    localparam int LAT_MAX   = 4 * SH + DB;

    logic       clk;
    logic       rst;
    logic [3:0] col_in;
    logic [3:0] row_scn;
    logic [3:0] key;
    logic       pressed;
    logic       held;

    logic [15:0] keys;
    logic        prev_pressed;
    int          checks;
    int          failures;

    keypad_event_scanner #(
        .SCAN_HOLD    (SH),
        .DEBOUNCE     (DB),
        .REPEAT_DELAY (REP_DELAY),
        .REPEAT_RATE  (REP_RATE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .col_in  (col_in),
        .row_scn (row_scn),
        .key     (key),
        .pressed (pressed),
        .held    (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a down key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_scn[r]) col_in[c] = 1'b0;
    end

    typedef struct {
        logic [15:0] mask;
        int          h;
        logic [3:0]  exp_key;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            checks++;
            if ($countones(~row_scn) != 1) begin
                failures++;
                $display("FAIL row_scn_onehot: actual=%b required=exactly one low bit", row_scn);
            end
        end
        checks++;
        if (pressed && prev_pressed) begin
            failures++;
            $display("FAIL pressed_width: actual=high two cycles required=single cycle");
        end
        prev_pressed = pressed;
    endtask

    task automatic wait_strobe(input int limit, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < limit) begin
            tick();
            lat++;
            got = pressed;
        end
    endtask

    // Press a key set, hold h cycles past the strobe, release, and compare strobe offsets.
    task automatic run_press(input string name, input logic [15:0] mask, input int h,
                             input logic [3:0] exp_key);
        int lat;
        bit got;
        int off;
        int offs[$];
        int exp_q[$];
        exp_q.push_back(0);
`ifdef KEYPAD_REPEAT_EN
        for (int t = REP_DELAY; t < h; t += REP_RATE) exp_q.push_back(t);
`endif
        keys = mask;
        wait_strobe(40, lat, got);
        check({name, "_strobe_seen"}, int'(got), 1);
        if (!got) begin
            keys = '0;
            repeat (20) tick();
            return;
        end
        check({name, "_latency_in_window"}, int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        check({name, "_key"}, int'(key), int'(exp_key));
        check({name, "_held"}, int'(held), 1);
        offs.push_back(0);
        off = 0;
        for (int i = 1; i < h; i++) begin
            tick();
            off++;
            if (pressed) offs.push_back(off);
        end
        keys = '0;
        for (int i = 0; i < DB - 1; i++) begin
            tick();
            off++;
            if (pressed) offs.push_back(off);
        end
        check({name, "_held_during_release_debounce"}, int'(held), 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            off++;
            if (pressed) offs.push_back(off);
        end
        check({name, "_held_after_release"}, int'(held), 0);
        for (int i = 0; i < 4 * SH + 2; i++) begin
            tick();
            off++;
            if (pressed) offs.push_back(off);
        end
        check({name, "_key_kept"}, int'(key), int'(exp_key));
        check({name, "_strobe_count"}, offs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({name, "_strobe_offset"}, (i < offs.size()) ? offs[i] : -1, exp_q[i]);
    endtask

    initial begin
        vec_t vecs[5];
        int   lat;
        bit   got;
        int   nstrobe;
        logic [3:0] last_row;

        vecs[0] = '{16'h0200, 22, 4'b1001};
        vecs[1] = '{16'h0090, 30, 4'b0100};
        vecs[2] = '{16'h8000, 53, 4'b1111};
        vecs[3] = '{16'h0001, 10, 4'b0000};
        vecs[4] = '{16'h1000, 38, 4'b1100};

        checks = 0;
        failures = 0;
        prev_pressed = 1'b0;
        keys = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_row_scn", int'(row_scn), 4'b1110);
        check("reset_key", int'(key), 0);
        check("reset_pressed", int'(pressed), 0);
        check("reset_held", int'(held), 0);
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 5; i++) run_press($sformatf("vec%0d", i), vecs[i].mask, vecs[i].h, vecs[i].exp_key);

        // Column 3 released while column 0 of the same row stays down.
        keys = 16'h0090;
        wait_strobe(40, lat, got);
        check("dual_strobe_seen", int'(got), 1);
        check("dual_key", int'(key), 4'b0100);
        nstrobe = 0;
        repeat (3) tick();
        keys = 16'h0010;
        repeat (8) begin tick(); if (pressed) nstrobe++; end
        check("dual_col3_release_held", int'(held), 1);
        keys = '0;
        lat = 0;
        while (held && lat < 12) begin tick(); lat++; if (pressed) nstrobe++; end
        check("dual_released", int'(held), 0);
        check("dual_extra_strobes", nstrobe, 0);
        repeat (10) tick();

        // Press bounce: sync to row 0, detect on row 2, break the window once.
        last_row = row_scn;
        lat = 0;
        do begin
            last_row = row_scn;
            tick();
            lat++;
        end while (!(row_scn == 4'b1110 && last_row != 4'b1110) && lat < 20);
        keys = 16'h0200;
        nstrobe = 0;
        repeat (3 * SH) begin tick(); if (pressed) nstrobe++; end
        check("bounce_row_frozen", int'(row_scn), 4'b1011);
        repeat (2) begin tick(); if (pressed) nstrobe++; end
        keys = '0;
        tick();
        if (pressed) nstrobe++;
        keys = 16'h0200;
        check("bounce_no_early_strobe", nstrobe, 0);
        wait_strobe(40, lat, got);
        check("bounce_strobe_seen", int'(got), 1);
        check("bounce_latency", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        check("bounce_key", int'(key), 4'b1001);
        nstrobe = 0;
        repeat (2) begin tick(); if (pressed) nstrobe++; end
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0000 : 16'h0200;
            tick();
            if (pressed) nstrobe++;
        end
        check("release_bounce_held", int'(held), 1);
        keys = '0;
        lat = 0;
        while (held && lat < 20) begin tick(); lat++; if (pressed) nstrobe++; end
        check("release_bounce_fell", int'(held), 0);
        check("release_bounce_no_strobe", nstrobe, 0);
        repeat (10) tick();

        // Reset while a key is held.
        keys = 16'h0001;
        wait_strobe(40, lat, got);
        check("rst_pre_strobe_seen", int'(got), 1);
        repeat (3) tick();
        check("rst_pre_held", int'(held), 1);
        keys = '0;
        rst = 1'b1;
        tick();
        check("rst_mid_row_scn", int'(row_scn), 4'b1110);
        check("rst_mid_held", int'(held), 0);
        check("rst_mid_pressed", int'(pressed), 0);
        check("rst_mid_key", int'(key), 0);
        tick();
        check("rst_hold_pressed", int'(pressed), 0);
        rst = 1'b0;
        nstrobe = 0;
        repeat (12) begin tick(); if (pressed || held) nstrobe++; end
        check("rst_after_quiet", nstrobe, 0);

        // Random single-row presses against the press/release rules.
        for (int n = 0; n < 30; n++) begin
            int r, c1, c2, h, gap;
            bit two;
            logic [15:0] m;
            r   = int'($urandom_range(0, 3));
            c1  = int'($urandom_range(0, 3));
            c2  = int'($urandom_range(0, 3));
            two = 1'($urandom_range(0, 1));
            h   = int'($urandom_range(2, 14));
            gap = int'($urandom_range(0, 7));
            m = 16'(1) << (r * 4 + c1);
            if (two) m = m | (16'(1) << (r * 4 + c2));
            repeat (gap) tick();
            run_press($sformatf("rnd%0d", n), m, h,
                      4'({2'(r), 2'((two && c2 < c1) ? c2 : c1)}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
